ps2_scancode_receiver: RTL and testbench

- Receives PS/2 keyboard frames on the ps2_clk/ps2_data lines, deserializes them and validates each 11-bit frame.
- Presents make codes as an 8-bit character with a one-cycle check strobe, which is exactly the character/check pair consumed by the glyph mask producer.
- Handles the F0 break prefix (key release) and the E0 extended prefix.
- Runs entirely in the Pixelclock domain (25 MHz).

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_filter.sv | 56 +++++
 rtl/ps2_scancode_receiver.sv | 165 ++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared encodings and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam int unsigned PS2_DATA_W     = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  localparam logic [PS2_DATA_W-1:0] PS2_BREAK = 8'hF0;
  localparam logic [PS2_DATA_W-1:0] PS2_EXT   = 8'hE0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } ps2_state_e;

  // Odd parity: the data bits together with the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, deglitches ps2_clk and emits a one-cycle
// pulse on each filtered falling edge.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic Pixelclock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  // Level flips only after FILTER_LEN consecutive samples that disagree with it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign fall   = fall_q;
  assign data_s = data_sync_q[1];

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words, validates them and presents
// make codes as a character/check pair with break and extended qualifiers.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          SUPPRESS_BREAK = 1'b1
) (
  input  logic                  Pixelclock,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [PS2_DATA_W-1:0] character,
  output logic                  check,
  output logic                  released,
  output logic                  extended,
  output logic                  frame_error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic data_s;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .Pixelclock(Pixelclock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall      (fall),
    .data_s    (data_s)
  );

  ps2_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_W-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  brk_q, brk_d;
  logic                  ext_q, ext_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [PS2_DATA_W-1:0] character_q, character_d;
  logic                  check_q, check_d;
  logic                  released_q, released_d;
  logic                  extended_q, extended_d;
  logic                  frame_error_q, frame_error_d;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      tmo_q         <= '0;
      character_q   <= '0;
      check_q       <= 1'b0;
      released_q    <= 1'b0;
      extended_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      tmo_q         <= tmo_d;
      character_q   <= character_d;
      check_q       <= check_d;
      released_q    <= released_d;
      extended_q    <= extended_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    tmo_d         = '0;
    character_d   = character_q;
    check_d       = 1'b0;
    released_d    = released_q;
    extended_d    = extended_q;
    frame_error_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[PS2_DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_W - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            state_d = ST_DONE;
          end else begin
            frame_error_d = 1'b1;
            brk_d         = 1'b0;
            ext_d         = 1'b0;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (shift_q == PS2_BREAK) begin
          brk_d = 1'b1;
        end else if (shift_q == PS2_EXT) begin
          ext_d = 1'b1;
        end else begin
          if (!(brk_q && SUPPRESS_BREAK)) begin
            character_d = shift_q;
            released_d  = brk_q;
            extended_d  = ext_q;
            check_d     = 1'b1;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-edge watchdog; a fall in the same cycle restarts it instead.
    if ((state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP) && !fall) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_error_d = 1'b1;
        brk_d         = 1'b0;
        ext_d         = 1'b0;
        state_d       = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  assign character   = character_q;
  assign check       = check_q;
  assign released    = released_q;
  assign extended    = extended_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Self-checking bench: two receivers (break suppressed / not suppressed) share
// one PS/2 line pair; results are compared per frame against a table and a model.
module tb_ps2_scancode_receiver;

  localparam int unsigned TMO = 2000;

  logic       Pixelclock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] character0, character1;
  logic       check0, check1, released0, released1, extended0, extended1, ferr0, ferr1;

  ps2_scancode_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .SUPPRESS_BREAK(1'b1)) u_dut_sb (
    .Pixelclock(Pixelclock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .character(character0), .check(check0), .released(released0),
    .extended(extended0), .frame_error(ferr0));

  ps2_scancode_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .SUPPRESS_BREAK(1'b0)) u_dut_nb (
    .Pixelclock(Pixelclock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .character(character1), .check(check1), .released(released1),
    .extended(extended1), .frame_error(ferr1));

  always #5 Pixelclock = ~Pixelclock;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters and values captured at each check, sampled on the falling edge.
  int         cyc = 0;
  int         chk_n[2] = '{0, 0};
  int         err_n[2] = '{0, 0};
  int         both_n = 0;
  logic [7:0] cap_char[2] = '{8'h00, 8'h00};
  logic       cap_rel[2]  = '{1'b0, 1'b0};
  logic       cap_ext[2]  = '{1'b0, 1'b0};

  always @(negedge Pixelclock) begin
    cyc = cyc + 1;
    if (reset) begin
      cap_char = '{8'h00, 8'h00};
      cap_rel  = '{1'b0, 1'b0};
      cap_ext  = '{1'b0, 1'b0};
    end else begin
      if (check0) begin
        chk_n[0]++; cap_char[0] = character0; cap_rel[0] = released0; cap_ext[0] = extended0;
      end
      if (check1) begin
        chk_n[1]++; cap_char[1] = character1; cap_rel[1] = released1; cap_ext[1] = extended1;
      end
      if (ferr0) err_n[0]++;
      if (ferr1) err_n[1]++;
      if ((check0 && ferr0) || (check1 && ferr1)) both_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Pixelclock);
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: per-receiver prefix state and last presented code.
  logic [7:0] m_char[2];
  logic       m_rel[2], m_xo[2], m_brk[2], m_ext[2];
  int         e_chk[2];
  int         e_err;
  int         s_chk[2], s_err[2];
  int         last_fall_cyc;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_char[d] = 8'h00; m_rel[d] = 1'b0; m_xo[d] = 1'b0; m_brk[d] = 1'b0; m_ext[d] = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    e_err = ok ? 0 : 1;
    for (int d = 0; d < 2; d++) begin
      e_chk[d] = 0;
      if (!ok) begin
        m_brk[d] = 1'b0; m_ext[d] = 1'b0;
      end else if (b == 8'hF0) begin
        m_brk[d] = 1'b1;
      end else if (b == 8'hE0) begin
        m_ext[d] = 1'b1;
      end else begin
        if (!(m_brk[d] && d == 0)) begin
          e_chk[d] = 1; m_char[d] = b; m_rel[d] = m_brk[d]; m_xo[d] = m_ext[d];
        end
        m_brk[d] = 1'b0; m_ext[d] = 1'b0;
      end
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_chk[d] = chk_n[d]; s_err[d] = err_n[d];
    end
  endtask

  // Device-side clocking: data changes mid-high, 40-cycle half periods.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      tick(20);
      ps2_data = bits[i];
      tick(20);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(40);
      ps2_clk = 1'b1;
    end
    tick(20);
    ps2_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bp, input bit bs);
    snap();
    send_bits(make_frame(b, bp, bs), 11);
    tick(60);
  endtask

  task automatic verify(input string tag, input int ec0, input int ec1,
                        input logic [7:0] ch0, input logic [7:0] ch1,
                        input logic r0, input logic r1, input logic x0, input logic x1,
                        input int er);
    cmp({tag, ".chk_sb"}, chk_n[0] - s_chk[0], ec0);
    cmp({tag, ".chk_nb"}, chk_n[1] - s_chk[1], ec1);
    cmp({tag, ".char_sb"}, int'(cap_char[0]), int'(ch0));
    cmp({tag, ".char_nb"}, int'(cap_char[1]), int'(ch1));
    cmp({tag, ".rel_sb"}, int'(cap_rel[0]), int'(r0));
    cmp({tag, ".rel_nb"}, int'(cap_rel[1]), int'(r1));
    cmp({tag, ".ext_sb"}, int'(cap_ext[0]), int'(x0));
    cmp({tag, ".ext_nb"}, int'(cap_ext[1]), int'(x1));
    cmp({tag, ".err_sb"}, err_n[0] - s_err[0], er);
    cmp({tag, ".err_nb"}, err_n[1] - s_err[1], er);
  endtask

  task automatic verify_model(input string tag);
    verify(tag, e_chk[0], e_chk[1], m_char[0], m_char[1], m_rel[0], m_rel[1],
           m_xo[0], m_xo[1], e_err);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bp;
    bit         bs;
    int         chk0;
    int         chk1;
    logic [7:0] ch0;
    logic [7:0] ch1;
    bit         rel1;
    bit         ext;
    int         err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] rb;
    int         r;
    int         e;
    bit         seen;

    tbl[0] = '{8'h2B, 1'b0, 1'b0, 1, 1, 8'h2B, 8'h2B, 1'b0, 1'b0, 0};
    tbl[1] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h2B, 8'h2B, 1'b0, 1'b0, 0};
    tbl[2] = '{8'h15, 1'b0, 1'b0, 0, 1, 8'h2B, 8'h15, 1'b1, 1'b0, 0};
    tbl[3] = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h2B, 8'h15, 1'b1, 1'b0, 0};
    tbl[4] = '{8'h33, 1'b0, 1'b0, 1, 1, 8'h33, 8'h33, 1'b0, 1'b1, 0};
    tbl[5] = '{8'h22, 1'b0, 1'b0, 1, 1, 8'h22, 8'h22, 1'b0, 1'b0, 0};
    tbl[6] = '{8'h2B, 1'b1, 1'b0, 0, 0, 8'h22, 8'h22, 1'b0, 1'b0, 1};
    tbl[7] = '{8'h2B, 1'b0, 1'b1, 0, 0, 8'h22, 8'h22, 1'b0, 1'b0, 1};

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    tick(5);
    cmp("reset.char", int'(character0), 0);
    cmp("reset.pulses", int'({check0, released0, extended0, ferr0, check1, released1, extended1, ferr1}), 0);
    reset = 1'b0;
    tick(20);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].b, tbl[i].bp, tbl[i].bs);
      model_frame(tbl[i].b, !(tbl[i].bp || tbl[i].bs));
      verify($sformatf("tbl%0d", i), tbl[i].chk0, tbl[i].chk1, tbl[i].ch0, tbl[i].ch1,
             1'b0, tbl[i].rel1, tbl[i].ext, tbl[i].ext, tbl[i].err);
    end

    // Short low glitches with data low must not start a frame.
    snap();
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(30);
    end
    ps2_data = 1'b1;
    tick(20);
    cmp("glitch.err", err_n[0] - s_err[0], 0);
    run_frame(8'h22, 1'b0, 1'b0);
    model_frame(8'h22, 1'b1);
    verify_model("glitch_frame");

    // Stall after start + 4 data bits: error after the inter-edge timeout.
    snap();
    send_bits(make_frame(8'h2B, 1'b0, 1'b0), 5);
    seen = 1'b0;
    for (int i = 0; i < TMO + 200 && !seen; i++) begin
      tick(1);
      if (err_n[0] != s_err[0]) seen = 1'b1;
    end
    cmp("stall.err_seen", int'(seen), 1);
    cmp("stall.delay_ok", int'((cyc - last_fall_cyc) >= int'(TMO) && (cyc - last_fall_cyc) <= int'(TMO) + 40), 1);
    tick(20);
    model_frame(8'h2B, 1'b0);
    verify_model("stall");
    run_frame(8'h22, 1'b0, 1'b0);
    model_frame(8'h22, 1'b1);
    verify_model("after_stall");

    // Reset in the middle of a frame discards it.
    send_bits(make_frame(8'h15, 1'b0, 1'b0), 5);
    reset = 1'b1;
    tick(5);
    cmp("midreset.char_sb", int'(character0), 0);
    cmp("midreset.char_nb", int'(character1), 0);
    cmp("midreset.pulses", int'({check0, released0, extended0, ferr0, check1, released1, extended1, ferr1}), 0);
    reset = 1'b0;
    model_reset();
    tick(20);
    run_frame(8'h15, 1'b0, 1'b0);
    model_frame(8'h15, 1'b1);
    verify_model("post_reset");

    // Randomized frames, biased towards prefixes and occasional bad frames.
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 9));
      e = int'($urandom_range(0, 7));
      rb = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
      run_frame(rb, e == 0, e == 1);
      model_frame(rb, !(e == 0 || e == 1));
      verify_model($sformatf("rnd%0d_%02h", k, rb));
    end

    cmp("check_err_overlap", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
